// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO port: bus widths and register indices.
package gpio_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] ADDR_OUT        = 4'd0;
  localparam logic [ADDR_W-1:0] ADDR_DIR        = 4'd1;
  localparam logic [ADDR_W-1:0] ADDR_OUT_SET    = 4'd2;
  localparam logic [ADDR_W-1:0] ADDR_OUT_CLR    = 4'd3;
  localparam logic [ADDR_W-1:0] ADDR_OUT_TGL    = 4'd4;
  localparam logic [ADDR_W-1:0] ADDR_IN         = 4'd5;
  localparam logic [ADDR_W-1:0] ADDR_RISE_EN    = 4'd6;
  localparam logic [ADDR_W-1:0] ADDR_FALL_EN    = 4'd7;
  localparam logic [ADDR_W-1:0] ADDR_IRQ_STATUS = 4'd8;
endpackage

// File: rtl/gpio_input_sync.sv
// Per-pin 2-flop synchroniser with optional debounce (enabled by GPIO_DEBOUNCE_EN).
module gpio_input_sync #(
  parameter int WIDTH           = 32,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] in_sync
);
  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= pins;
      sync <= meta;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] stable;

  // The counter only advances while the synchronised value disagrees with the
  // accepted value; any sample that agrees again restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync[i] != stable[i]) begin
          if (cnt[i] == CNT_LAST) begin
            stable[i] <= sync[i];
            cnt[i]    <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign in_sync = stable;
`else
  logic unused_cfg;
  assign unused_cfg = |DEBOUNCE_CYCLES;
  assign in_sync    = sync;
`endif
endmodule

// File: rtl/gpio_port.sv
// WIDTH-pin GPIO port: direction/output registers, synchronised input view and
// edge-capture interrupt. Input debounce is enabled with GPIO_DEBOUNCE_EN.
module gpio_port
  import gpio_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] dataIn,
  output logic [DATA_W-1:0] dataOut,
  output logic              irq,
  inout  wire  [WIDTH-1:0]  io
);
  logic [WIDTH-1:0] out_q, dir_q, rise_en_q, fall_en_q, status_q, prev_q;
  logic [WIDTH-1:0] out_d, dir_d, rise_en_d, fall_en_d, status_d;
  logic [WIDTH-1:0] in_val, wdata, clr_mask, capture, rd_val;
  logic             wr, rd;

  assign wr    = cs & we;
  assign rd    = cs & ~we;
  assign wdata = dataIn[WIDTH-1:0];

  gpio_input_sync #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .pins   (io),
    .in_sync(in_val)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign io[i] = dir_q[i] ? out_q[i] : 1'bz;
  end

  assign capture = (in_val & ~prev_q & rise_en_q) | (~in_val & prev_q & fall_en_q);

  always_comb begin
    out_d     = out_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    clr_mask  = '0;
    if (wr) begin
      case (addr)
        ADDR_OUT:        out_d     = wdata;
        ADDR_DIR:        dir_d     = wdata;
        ADDR_OUT_SET:    out_d     = out_q | wdata;
        ADDR_OUT_CLR:    out_d     = out_q & ~wdata;
        ADDR_OUT_TGL:    out_d     = out_q ^ wdata;
        ADDR_RISE_EN:    rise_en_d = wdata;
        ADDR_FALL_EN:    fall_en_d = wdata;
        ADDR_IRQ_STATUS: clr_mask  = wdata;
        default:         ;
      endcase
    end
    // A fresh edge outranks a write-1-to-clear landing in the same cycle.
    status_d = (status_q & ~clr_mask) | capture;
  end

  always_comb begin
    rd_val = '0;
    case (addr)
      ADDR_OUT, ADDR_OUT_SET, ADDR_OUT_CLR, ADDR_OUT_TGL: rd_val = out_q;
      ADDR_DIR:        rd_val = dir_q;
      ADDR_IN:         rd_val = in_val;
      ADDR_RISE_EN:    rd_val = rise_en_q;
      ADDR_FALL_EN:    rd_val = fall_en_q;
      ADDR_IRQ_STATUS: rd_val = status_q;
      default:         rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      prev_q    <= '0;
      dataOut   <= '0;
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      prev_q    <= in_val;
      if (rd) dataOut <= DATA_W'(rd_val);
    end
  end

  assign irq = |status_q;
endmodule

// File: tb/tb_gpio_port.sv
// Bench for gpio_port at WIDTH=8: register table, input timing, edge capture, reset.
module tb_gpio_port;
  import gpio_pkg::*;

  localparam int W  = 8;
  localparam int DB = 4;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = 2 + DB;
`else
  localparam int LAT = 2;
`endif
  localparam int NV = 22;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] data_in = '0;
  wire  [31:0] data_out;
  wire         irq;
  wire  [W-1:0] io;
  logic [W-1:0] drv_val = '0;
  logic [W-1:0] drv_en = '0;

  for (genvar i = 0; i < W; i++) begin : g_drv
    assign io[i] = drv_en[i] ? drv_val[i] : 1'bz;
  end

  gpio_port #(.WIDTH(W), .DEBOUNCE_CYCLES(DB)) dut (
    .clk    (clk),
    .rst    (rst),
    .cs     (cs),
    .we     (we),
    .addr   (addr),
    .dataIn (data_in),
    .dataOut(data_out),
    .irq    (irq),
    .io     (io)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [3:0]  a;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [NV];

  logic [31:0] exp_q[$];
  logic [3:0]  addr_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        rd_seen = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every read pushes its expected value; data_out is compared on
  // the falling edge after the read's clock edge.
  always @(posedge clk) rd_seen <= cs && !we && !rst;
  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rd_unexpected: got %h with nothing queued", data_out);
      end else begin
        check32($sformatf("rd addr %0d", addr_q.pop_front()), data_out, exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    cs = 1'b1; we = 1'b1; addr = a; data_in = d;
    tick(1);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [31:0] e);
    cs = 1'b1; we = 1'b0; addr = a;
    exp_q.push_back(e);
    addr_q.push_back(a);
    tick(1);
    cs = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "timeout");
  end

  initial begin
    vecs = '{
      '{1'b1, ADDR_DIR,        32'h0000_00FF, 32'h0},
      '{1'b1, ADDR_OUT,        32'h0000_00A5, 32'h0},
      '{1'b1, ADDR_OUT_SET,    32'h0000_0002, 32'h0},
      '{1'b1, ADDR_OUT_CLR,    32'h0000_0080, 32'h0},
      '{1'b1, ADDR_OUT_TGL,    32'h0000_000F, 32'h0},
      '{1'b0, ADDR_OUT,        32'h0,         32'h0000_0028},
      '{1'b0, ADDR_OUT_SET,    32'h0,         32'h0000_0028},
      '{1'b0, ADDR_OUT_CLR,    32'h0,         32'h0000_0028},
      '{1'b0, ADDR_OUT_TGL,    32'h0,         32'h0000_0028},
      '{1'b0, ADDR_DIR,        32'h0,         32'h0000_00FF},
      '{1'b1, ADDR_FALL_EN,    32'h0000_005A, 32'h0},
      '{1'b0, ADDR_FALL_EN,    32'h0,         32'h0000_005A},
      '{1'b1, ADDR_FALL_EN,    32'h0,         32'h0},
      '{1'b1, ADDR_RISE_EN,    32'hFFFF_FF3C, 32'h0},
      '{1'b0, ADDR_RISE_EN,    32'h0,         32'h0000_003C},
      '{1'b1, ADDR_RISE_EN,    32'h0,         32'h0},
      '{1'b1, 4'd9,            32'hFFFF_FFFF, 32'h0},
      '{1'b0, 4'd9,            32'h0,         32'h0},
      '{1'b0, 4'd15,           32'h0,         32'h0},
      '{1'b1, ADDR_OUT,        32'hFFFF_FF28, 32'h0},
      '{1'b0, ADDR_OUT,        32'h0,         32'h0000_0028},
      '{1'b0, ADDR_IRQ_STATUS, 32'h0,         32'h0}
    };

    // Reset with a concurrent write attempt; reset must win.
    drv_en = '1; drv_val = '0;
    cs = 1'b1; we = 1'b1; addr = ADDR_DIR; data_in = 32'hFFFF_FFFF;
    tick(3);
    rst = 1'b0; cs = 1'b0; we = 1'b0;
    check32("reset irq", {31'b0, irq}, 32'h0);
    check32("reset data_out", data_out, 32'h0);
    for (int a = 0; a < 16; a++) bus_read(4'(a), 32'h0);

    drv_en = '0;
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].a, vecs[i].wdata);
      else            bus_read(vecs[i].a, vecs[i].exp);
    end
    check32("io driven", {24'b0, io}, 32'h0000_0028);
    tick(LAT);
    bus_read(ADDR_IN, 32'h0000_0028);

    // Output pins feed back through IN and are captured too.
    bus_write(ADDR_RISE_EN, 32'h01);
    bus_write(ADDR_OUT_SET, 32'h01);
    tick(LAT + 1);
    bus_read(ADDR_IRQ_STATUS, 32'h01);
    check32("out capture irq", {31'b0, irq}, 32'h1);
    bus_write(ADDR_RISE_EN, 32'h0);
    bus_write(ADDR_IRQ_STATUS, 32'h01);
    check32("out capture cleared irq", {31'b0, irq}, 32'h0);

    // Release the pins and drive them from the bench.
    bus_write(ADDR_DIR, 32'h0);
    drv_val = '0; drv_en = '1;
    tick(LAT + 2);
    bus_read(ADDR_IN, 32'h0);

    // Rising edge on pin 0: IN and irq latency.
    bus_write(ADDR_RISE_EN, 32'h01);
    drv_val[0] = 1'b1;
    for (int j = 0; j <= LAT; j++) begin
      bus_read(ADDR_IN, (j >= LAT) ? 32'h01 : 32'h00);
      check32($sformatf("rise irq edge+%0d", j), {31'b0, irq}, (j >= LAT) ? 32'h1 : 32'h0);
    end
    bus_read(ADDR_IRQ_STATUS, 32'h01);
    bus_write(ADDR_IRQ_STATUS, 32'h01);
    check32("rise w1c irq", {31'b0, irq}, 32'h0);
    bus_read(ADDR_IRQ_STATUS, 32'h0);

    // Falling edge on pin 2 collides with a clear of bit 2: set wins.
    drv_val[2] = 1'b1;
    tick(LAT + 2);
    bus_write(ADDR_FALL_EN, 32'h04);
    drv_val[2] = 1'b0;
    tick(LAT);
    bus_write(ADDR_IRQ_STATUS, 32'h04);
    bus_read(ADDR_IRQ_STATUS, 32'h04);
    check32("fall collide irq", {31'b0, irq}, 32'h1);
    bus_write(ADDR_FALL_EN, 32'h0);
    bus_read(ADDR_IRQ_STATUS, 32'h04);
    bus_write(ADDR_IRQ_STATUS, 32'h04);
    bus_read(ADDR_IRQ_STATUS, 32'h0);
    check32("fall cleared irq", {31'b0, irq}, 32'h0);

`ifdef GPIO_DEBOUNCE_EN
    // A 3-cycle glitch is shorter than the debounce window.
    bus_write(ADDR_RISE_EN, 32'h02);
    drv_val[1] = 1'b1;
    tick(3);
    drv_val[1] = 1'b0;
    tick(LAT + 4);
    bus_read(ADDR_IN, 32'h01);
    bus_read(ADDR_IRQ_STATUS, 32'h0);
    bus_write(ADDR_RISE_EN, 32'h0);
`endif

    // Fill STATUS with all pins rising, then reset mid-access.
    drv_en = '0;
    bus_write(ADDR_OUT, 32'h0);
    bus_write(ADDR_DIR, 32'hFF);
    bus_write(ADDR_RISE_EN, 32'hFF);
    bus_write(ADDR_FALL_EN, 32'hFF);
    tick(LAT + 2);
    bus_write(ADDR_OUT, 32'hFF);
    tick(LAT + 1);
    bus_read(ADDR_IRQ_STATUS, 32'hFF);
    check32("full status irq", {31'b0, irq}, 32'h1);
    rst = 1'b1; cs = 1'b1; we = 1'b1; addr = ADDR_OUT; data_in = 32'hFF;
    tick(1);
    check32("mid reset irq", {31'b0, irq}, 32'h0);
    check32("mid reset data_out", data_out, 32'h0);
    rst = 1'b0; cs = 1'b0; we = 1'b0;
    bus_read(ADDR_OUT, 32'h0);
    bus_read(ADDR_DIR, 32'h0);
    bus_read(ADDR_RISE_EN, 32'h0);
    bus_read(ADDR_FALL_EN, 32'h0);
    bus_read(ADDR_IRQ_STATUS, 32'h0);
    drv_val = 8'h5A; drv_en = '1;
    tick(LAT + 1);
    bus_read(ADDR_IN, 32'h5A);
    bus_read(ADDR_IRQ_STATUS, 32'h0);

    tick(2);
    check32("queue drained", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
